// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if -- writeback-to-CDB bundle.
//   Three writeback streams (alu/lsu/branch): valid, ready, tag, dest, data;
//   the branch stream also carries the resolved direction and target.
//   CDB broadcast side: valid, tag, dest, data, reg_write and branch info.
//   master: the execution-unit / consumer side; slave: the arbiter.
interface cdb_arbiter_if #(
   parameter int TAG_W  = 4,
   parameter int PRD_W  = 7,
   parameter int DATA_W = 32
);
   logic              alu_wb_valid;
   logic              alu_wb_ready;
   logic [TAG_W-1:0]  alu_cdb_tag;
   logic [PRD_W-1:0]  alu_wb_dest;
   logic [DATA_W-1:0] alu_wb_data;

   logic              lsu_wb_valid;
   logic              lsu_wb_ready;
   logic [TAG_W-1:0]  lsu_cdb_tag;
   logic [PRD_W-1:0]  lsu_wb_dest;
   logic [DATA_W-1:0] lsu_wb_data;

   logic              branch_wb_valid;
   logic              branch_wb_ready;
   logic [TAG_W-1:0]  branch_cdb_tag;
   logic [PRD_W-1:0]  branch_wb_dest;
   logic [DATA_W-1:0] branch_wb_data;
   logic              branch_taken;
   logic [DATA_W-1:0] branch_target_addr;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [PRD_W-1:0]  cdb_dest;
   logic [DATA_W-1:0] cdb_data;
   logic              cdb_reg_write;
   logic              cdb_is_branch;
   logic              cdb_br_taken;
   logic [DATA_W-1:0] cdb_br_target;

   modport master (
      output alu_wb_valid, alu_cdb_tag, alu_wb_dest, alu_wb_data,
      output lsu_wb_valid, lsu_cdb_tag, lsu_wb_dest, lsu_wb_data,
      output branch_wb_valid, branch_cdb_tag, branch_wb_dest, branch_wb_data,
      output branch_taken, branch_target_addr,
      input  alu_wb_ready, lsu_wb_ready, branch_wb_ready,
      input  cdb_valid, cdb_tag, cdb_dest, cdb_data, cdb_reg_write,
      input  cdb_is_branch, cdb_br_taken, cdb_br_target
   );

   modport slave (
      input  alu_wb_valid, alu_cdb_tag, alu_wb_dest, alu_wb_data,
      input  lsu_wb_valid, lsu_cdb_tag, lsu_wb_dest, lsu_wb_data,
      input  branch_wb_valid, branch_cdb_tag, branch_wb_dest, branch_wb_data,
      input  branch_taken, branch_target_addr,
      output alu_wb_ready, lsu_wb_ready, branch_wb_ready,
      output cdb_valid, cdb_tag, cdb_dest, cdb_data, cdb_reg_write,
      output cdb_is_branch, cdb_br_taken, cdb_br_target
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- merges ALU, LSU and branch writeback onto the single CDB.
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active low
//   flush : synchronous pipeline flush; empties all FIFOs, drops the broadcast
//   bus   : cdb_arbiter_if.slave -- three writeback streams in, CDB out
// Each source owns a DEPTH-entry FIFO. One head is popped per cycle into the
// registered CDB outputs: branch has strict priority, ALU/LSU alternate.
module cdb_arbiter #(
   parameter int TAG_W  = 4,
   parameter int PRD_W  = 7,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input logic           clk,
   input logic           rst,
   input logic           flush,
   cdb_arbiter_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_LSU = 2'd1;
   localparam logic [1:0] SRC_BR  = 2'd2;

   localparam logic [0:0] RR_ALU = 1'b0;
   localparam logic [0:0] RR_LSU = 1'b1;

   // per-source input view, indexed by SRC_*
   logic              in_valid [3];
   logic [TAG_W-1:0]  in_tag   [3];
   logic [PRD_W-1:0]  in_dest  [3];
   logic [DATA_W-1:0] in_data  [3];

   // FIFO storage and bookkeeping
   logic [TAG_W-1:0]  tag_mem  [3][DEPTH];
   logic [PRD_W-1:0]  dest_mem [3][DEPTH];
   logic [DATA_W-1:0] data_mem [3][DEPTH];
   logic              br_taken_mem  [DEPTH];
   logic [DATA_W-1:0] br_target_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr [3];
   logic [PTR_W-1:0]  rd_ptr [3];
   logic [CNT_W-1:0]  count  [3];

   logic [2:0]        ready_vec;
   logic [2:0]        push_vec;
   logic [2:0]        pop_vec;
   logic              grant_valid;
   logic [1:0]        grant_src;
   logic [0:0]        rr_ptr;

   // registered CDB outputs
   logic              out_valid;
   logic [TAG_W-1:0]  out_tag;
   logic [PRD_W-1:0]  out_dest;
   logic [DATA_W-1:0] out_data;
   logic              out_is_branch;
   logic              out_br_taken;
   logic [DATA_W-1:0] out_br_target;

   always_comb begin
      in_valid[SRC_ALU] = bus.alu_wb_valid;
      in_tag[SRC_ALU]   = bus.alu_cdb_tag;
      in_dest[SRC_ALU]  = bus.alu_wb_dest;
      in_data[SRC_ALU]  = bus.alu_wb_data;
      in_valid[SRC_LSU] = bus.lsu_wb_valid;
      in_tag[SRC_LSU]   = bus.lsu_cdb_tag;
      in_dest[SRC_LSU]  = bus.lsu_wb_dest;
      in_data[SRC_LSU]  = bus.lsu_wb_data;
      in_valid[SRC_BR]  = bus.branch_wb_valid;
      in_tag[SRC_BR]    = bus.branch_cdb_tag;
      in_dest[SRC_BR]   = bus.branch_wb_dest;
      in_data[SRC_BR]   = bus.branch_wb_data;
   end

   // Ready depends on occupancy only (not on a same-cycle pop); gating with
   // rst keeps every ready low while reset is held.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         ready_vec[i] = rst && (count[i] < CNT_W'(DEPTH));
         push_vec[i]  = in_valid[i] && ready_vec[i];
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_src   = SRC_ALU;
      if (count[SRC_BR] != '0) begin
         grant_valid = 1'b1;
         grant_src   = SRC_BR;
      end else if (count[SRC_ALU] != '0 && count[SRC_LSU] != '0) begin
         grant_valid = 1'b1;
         grant_src   = (rr_ptr == RR_ALU) ? SRC_ALU : SRC_LSU;
      end else if (count[SRC_ALU] != '0) begin
         grant_valid = 1'b1;
         grant_src   = SRC_ALU;
      end else if (count[SRC_LSU] != '0) begin
         grant_valid = 1'b1;
         grant_src   = SRC_LSU;
      end
   end

   always_comb begin
      pop_vec            = '0;
      pop_vec[grant_src] = grant_valid;
   end

   // Payload storage needs no reset: validity is tracked by count alone.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 3; i++) begin
         if (push_vec[i]) begin
            tag_mem[i][wr_ptr[i]]  <= in_tag[i];
            dest_mem[i][wr_ptr[i]] <= in_dest[i];
            data_mem[i][wr_ptr[i]] <= in_data[i];
         end
      end
      if (push_vec[SRC_BR]) begin
         br_taken_mem[wr_ptr[SRC_BR]]  <= bus.branch_taken;
         br_target_mem[wr_ptr[SRC_BR]] <= bus.branch_target_addr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 3; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < 3; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (push_vec[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop_vec[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            case ({push_vec[i], pop_vec[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         out_tag       <= '0;
         out_dest      <= '0;
         out_data      <= '0;
         out_is_branch <= 1'b0;
         out_br_taken  <= 1'b0;
         out_br_target <= '0;
         rr_ptr        <= RR_ALU;
      end else if (flush) begin
         out_valid <= 1'b0;
         rr_ptr    <= RR_ALU;
      end else if (grant_valid) begin
         out_valid <= 1'b1;
         out_tag   <= tag_mem[grant_src][rd_ptr[grant_src]];
         out_dest  <= dest_mem[grant_src][rd_ptr[grant_src]];
         out_data  <= data_mem[grant_src][rd_ptr[grant_src]];
         if (grant_src == SRC_BR) begin
            out_is_branch <= 1'b1;
            out_br_taken  <= br_taken_mem[rd_ptr[SRC_BR]];
            out_br_target <= br_target_mem[rd_ptr[SRC_BR]];
         end else begin
            out_is_branch <= 1'b0;
            out_br_taken  <= 1'b0;
            out_br_target <= '0;
            rr_ptr        <= (grant_src == SRC_ALU) ? RR_LSU : RR_ALU;
         end
      end else begin
         out_valid <= 1'b0;
      end
   end

   assign bus.alu_wb_ready    = ready_vec[SRC_ALU];
   assign bus.lsu_wb_ready    = ready_vec[SRC_LSU];
   assign bus.branch_wb_ready = ready_vec[SRC_BR];
   assign bus.cdb_valid       = out_valid;
   assign bus.cdb_tag         = out_tag;
   assign bus.cdb_dest        = out_dest;
   assign bus.cdb_data        = out_data;
   assign bus.cdb_reg_write   = out_valid && (out_dest != '0);
   assign bus.cdb_is_branch   = out_is_branch;
   assign bus.cdb_br_taken    = out_br_taken;
   assign bus.cdb_br_target   = out_br_target;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter -- directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the three source FIFOs.
module tb_cdb_arbiter;
   localparam int TAG_W  = 4;
   localparam int PRD_W  = 7;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.TAG_W(TAG_W), .PRD_W(PRD_W), .DATA_W(DATA_W)) bus ();

   cdb_arbiter #(.TAG_W(TAG_W), .PRD_W(PRD_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [PRD_W-1:0]  dest;
      logic [DATA_W-1:0] data;
      logic              taken;
      logic [DATA_W-1:0] target;
   } ent_t;

   ent_t qa[$];
   ent_t ql[$];
   ent_t qb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // model: expected CDB registers and round-robin preference (0 = ALU next)
   logic              e_valid;
   logic [TAG_W-1:0]  e_tag;
   logic [PRD_W-1:0]  e_dest;
   logic [DATA_W-1:0] e_data;
   logic              e_isbr;
   logic              e_taken;
   logic [DATA_W-1:0] e_target;
   bit                m_rr;
   bit                acc_a, acc_l, acc_b;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic [TAG_W-1:0] t, input logic [PRD_W-1:0] d,
                               input logic [DATA_W-1:0] v, input logic tk,
                               input logic [DATA_W-1:0] tg);
      ent_t e;
      e.tag = t; e.dest = d; e.data = v; e.taken = tk; e.target = tg;
      return e;
   endfunction

   task automatic model_reset();
      qa.delete(); ql.delete(); qb.delete();
      m_rr = 0;
      e_valid = 0; e_tag = '0; e_dest = '0; e_data = '0;
      e_isbr = 0; e_taken = 0; e_target = '0;
   endtask

   task automatic load(input ent_t e, input bit isbr);
      e_valid  = 1;
      e_tag    = e.tag;
      e_dest   = e.dest;
      e_data   = e.data;
      e_isbr   = isbr;
      e_taken  = isbr ? e.taken : 1'b0;
      e_target = isbr ? e.target : '0;
   endtask

   task automatic compare_all();
      check("cdb_valid",     64'(bus.cdb_valid),     64'(e_valid));
      check("cdb_tag",       64'(bus.cdb_tag),       64'(e_tag));
      check("cdb_dest",      64'(bus.cdb_dest),      64'(e_dest));
      check("cdb_data",      64'(bus.cdb_data),      64'(e_data));
      check("cdb_reg_write", 64'(bus.cdb_reg_write), 64'(e_valid && e_dest != 0));
      check("cdb_is_branch", 64'(bus.cdb_is_branch), 64'(e_isbr));
      check("cdb_br_taken",  64'(bus.cdb_br_taken),  64'(e_taken));
      check("cdb_br_target", 64'(bus.cdb_br_target), 64'(e_target));
      check("alu_ready",     64'(bus.alu_wb_ready),    64'(rst && qa.size() < DEPTH));
      check("lsu_ready",     64'(bus.lsu_wb_ready),    64'(rst && ql.size() < DEPTH));
      check("branch_ready",  64'(bus.branch_wb_ready), 64'(rst && qb.size() < DEPTH));
   endtask

   task automatic idle_inputs();
      bus.alu_wb_valid = 0; bus.lsu_wb_valid = 0; bus.branch_wb_valid = 0;
      flush = 0;
   endtask

   task automatic set_alu(input int t, input int d, input int v);
      bus.alu_wb_valid = 1; bus.alu_cdb_tag = TAG_W'(t);
      bus.alu_wb_dest = PRD_W'(d); bus.alu_wb_data = DATA_W'(v);
   endtask

   task automatic set_lsu(input int t, input int d, input int v);
      bus.lsu_wb_valid = 1; bus.lsu_cdb_tag = TAG_W'(t);
      bus.lsu_wb_dest = PRD_W'(d); bus.lsu_wb_data = DATA_W'(v);
   endtask

   task automatic set_br(input int t, input int d, input int v, input bit tk, input int tg);
      bus.branch_wb_valid = 1; bus.branch_cdb_tag = TAG_W'(t);
      bus.branch_wb_dest = PRD_W'(d); bus.branch_wb_data = DATA_W'(v);
      bus.branch_taken = tk; bus.branch_target_addr = DATA_W'(tg);
   endtask

   // Called at a negedge with inputs set: advance the model over the coming
   // edge, then let the DUT take the edge and compare at the next negedge.
   task automatic cycle();
      ent_t e;
      bit ra, rl, rb;
      ra = qa.size() < DEPTH;
      rl = ql.size() < DEPTH;
      rb = qb.size() < DEPTH;
      acc_a = bus.alu_wb_valid && ra && !flush;
      acc_l = bus.lsu_wb_valid && rl && !flush;
      acc_b = bus.branch_wb_valid && rb && !flush;
      if (flush) begin
         qa.delete(); ql.delete(); qb.delete();
         e_valid = 0;
         m_rr = 0;
      end else begin
         if (qb.size() > 0) begin
            e = qb.pop_front(); load(e, 1);
         end else if (qa.size() > 0 && (ql.size() == 0 || m_rr == 0)) begin
            e = qa.pop_front(); load(e, 0); m_rr = 1;
         end else if (ql.size() > 0) begin
            e = ql.pop_front(); load(e, 0); m_rr = 0;
         end else begin
            e_valid = 0;
         end
         if (acc_a) qa.push_back(mk(bus.alu_cdb_tag, bus.alu_wb_dest, bus.alu_wb_data, 1'b0, '0));
         if (acc_l) ql.push_back(mk(bus.lsu_cdb_tag, bus.lsu_wb_dest, bus.lsu_wb_data, 1'b0, '0));
         if (acc_b) qb.push_back(mk(bus.branch_cdb_tag, bus.branch_wb_dest, bus.branch_wb_data,
                                    bus.branch_taken, bus.branch_target_addr));
      end
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int sent;
      int alu_seen[$];

      bus.alu_wb_valid = 0; bus.alu_cdb_tag = '0; bus.alu_wb_dest = '0; bus.alu_wb_data = '0;
      bus.lsu_wb_valid = 0; bus.lsu_cdb_tag = '0; bus.lsu_wb_dest = '0; bus.lsu_wb_data = '0;
      bus.branch_wb_valid = 0; bus.branch_cdb_tag = '0; bus.branch_wb_dest = '0;
      bus.branch_wb_data = '0; bus.branch_taken = 0; bus.branch_target_addr = '0;
      model_reset();

      // reset state: everything 0, including readies
      repeat (3) @(negedge clk);
      compare_all();
      rst = 1;
      #1 compare_all();
      @(negedge clk);

      // single ALU result: visible one edge after the push, gone the next
      set_alu(0, 32, 10); cycle();
      idle_inputs(); cycle();
      check("t1_valid", 64'(bus.cdb_valid), 64'd1);
      check("t1_tag", 64'(bus.cdb_tag), 64'd0);
      check("t1_data", 64'(bus.cdb_data), 64'd10);
      check("t1_regw", 64'(bus.cdb_reg_write), 64'd1);
      cycle();
      check("t1_after", 64'(bus.cdb_valid), 64'd0);

      // LSU store: broadcast with dest 0, no register write
      set_lsu(3, 0, 32'h55); cycle();
      idle_inputs(); cycle();
      check("st_valid", 64'(bus.cdb_valid), 64'd1);
      check("st_regw", 64'(bus.cdb_reg_write), 64'd0);

      // three simultaneous completions: branch first, then ALU, then LSU
      set_alu(1, 33, 20); set_lsu(4, 35, 30); set_br(5, 0, 0, 1'b1, 32'h1C); cycle();
      idle_inputs(); cycle();
      check("tri_0_tag", 64'(bus.cdb_tag), 64'd5);
      check("tri_0_br", 64'(bus.cdb_is_branch), 64'd1);
      check("tri_0_tgt", 64'(bus.cdb_br_target), 64'h1C);
      cycle();
      check("tri_1_tag", 64'(bus.cdb_tag), 64'd1);
      cycle();
      check("tri_2_tag", 64'(bus.cdb_tag), 64'd4);
      cycle();

      // branch stream starves ALU; ALU FIFO fills, then drains in order
      sent = 0;
      for (int i = 0; i < 14; i++) begin
         idle_inputs();
         if (i < 6) set_br(8 + i, 0, i, 1'b0, 64 + i);
         if (sent < 3) set_alu(sent + 1, 40 + sent, 100 + sent);
         cycle();
         if (acc_a) sent++;
         if (bus.cdb_valid && !bus.cdb_is_branch) alu_seen.push_back(int'(bus.cdb_tag));
         if (i == 5) check("bp_alu_full", 64'(bus.alu_wb_ready), 64'd0);
      end
      check("bp_alu_count", 64'(alu_seen.size()), 64'd3);
      for (int i = 0; i < alu_seen.size() && i < 3; i++)
         check("bp_alu_order", 64'(alu_seen[i]), 64'(i + 1));
      idle_inputs();

      // flush with queued entries and a same-cycle push
      set_alu(6, 50, 1); set_lsu(7, 51, 2); set_br(8, 0, 3, 1'b1, 4); cycle();
      idle_inputs(); set_alu(9, 52, 5); cycle();
      idle_inputs(); set_alu(10, 53, 6); flush = 1; cycle();
      check("fl_valid", 64'(bus.cdb_valid), 64'd0);
      check("fl_ready", 64'({bus.alu_wb_ready, bus.lsu_wb_ready, bus.branch_wb_ready}), 64'h7);
      idle_inputs();
      repeat (3) cycle();
      check("fl_drained", 64'(bus.cdb_valid), 64'd0);

      // random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         idle_inputs();
         if ($urandom_range(0, 99) < 55)
            set_alu(int'($urandom_range(0, 15)), int'($urandom_range(0, 127)), int'($urandom));
         if ($urandom_range(0, 99) < 45)
            set_lsu(int'($urandom_range(0, 15)), int'($urandom_range(0, 127)), int'($urandom));
         if ($urandom_range(0, 99) < 25)
            set_br(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom),
                   1'($urandom), int'($urandom));
         flush = ($urandom_range(0, 49) == 0);
         cycle();
      end

      // asynchronous reset between edges while traffic is queued
      idle_inputs();
      set_alu(11, 60, 7); set_lsu(12, 61, 8); set_br(13, 62, 9, 1'b1, 10); cycle();
      idle_inputs(); cycle();
      #2 rst = 0;
      model_reset();
      #1 compare_all();
      @(negedge clk);
      rst = 1;
      #1 compare_all();
      @(negedge clk);
      set_alu(2, 40, 77); set_lsu(6, 41, 88); cycle();
      idle_inputs(); cycle();
      check("rst_first_tag", 64'(bus.cdb_tag), 64'd2);
      cycle();
      check("rst_second_tag", 64'(bus.cdb_tag), 64'd6);
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
